// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: load-use bubbles, redirect flushes,
// the MDU start/done handshake and DMEM wait-state freezes, plus stall/flush counters.
module hazard_ctrl #(
  parameter int LOAD_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic        rs1_used_d,
  input  logic        rs2_used_d,
  input  logic [4:0]  rd_e,
  input  logic        MemRead_e,
  input  logic        redirect_e,
  input  logic        mdu_op_e,
  input  logic        mdu_done,
  output logic        mdu_go,
  input  logic        mem_req_m,
  input  logic        mem_ready,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_m,
  output logic        flush_w,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {RUN, LU_STALL, MDU_WAIT} state_t;

  state_t      state_q, state_d;
  logic        lu_cnt_q, lu_cnt_d;
  logic        done_pend_q, done_pend_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;
  logic        lu, mw, flush_inc;

  assign lu = MemRead_e && (rd_e != 5'd0) &&
              ((rs1_used_d && rs1_d == rd_e) || (rs2_used_d && rs2_d == rd_e));
  assign mw = mem_req_m && !mem_ready;

  always_comb begin
    state_d     = state_q;
    lu_cnt_d    = lu_cnt_q;
    done_pend_d = done_pend_q;
    flush_inc   = 1'b0;
    mdu_go      = 1'b0;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_m     = 1'b0;
    flush_w     = 1'b0;

    if (mw) begin
      // Full freeze: FSM and lu_cnt hold, a done pulse is remembered for later.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
      if (mdu_done) done_pend_d = 1'b1;
    end else begin
      case (state_q)
        MDU_WAIT: begin
          if (mdu_done || done_pend_q) begin
            done_pend_d = 1'b0;
            state_d     = RUN;
          end else begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
          end
        end
        LU_STALL: begin
          lu_cnt_d = 1'b0;
          state_d  = RUN;
          if (redirect_e) begin
            flush_d   = 1'b1;
            flush_e   = 1'b1;
            flush_inc = 1'b1;
          end else begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end
        default: begin
          if (mdu_op_e) begin
            mdu_go = 1'b1;
            // A done arriving together with the start pulse releases EX at once.
            if (!mdu_done) begin
              stall_f = 1'b1;
              stall_d = 1'b1;
              stall_e = 1'b1;
              flush_m = 1'b1;
              state_d = MDU_WAIT;
            end
          end else if (redirect_e) begin
            flush_d   = 1'b1;
            flush_e   = 1'b1;
            flush_inc = 1'b1;
            lu_cnt_d  = 1'b0;
          end else if (lu) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
            if (LOAD_BUBBLES == 2) begin
              lu_cnt_d = 1'b1;
              state_d  = LU_STALL;
            end
          end
        end
      endcase
    end

    stall_cycles_d = stall_cycles_q + {31'd0, stall_f};
    flush_count_d  = flush_count_q + {31'd0, flush_inc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      lu_cnt_q       <= 1'b0;
      done_pend_q    <= 1'b0;
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      state_q        <= state_d;
      lu_cnt_q       <= lu_cnt_d;
      done_pend_q    <= done_pend_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; two instances (LOAD_BUBBLES=1 and 2) share one stimulus.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rs1_d, rs2_d, rd_e;
  logic rs1_used_d, rs2_used_d, MemRead_e, redirect_e, mdu_op_e, mdu_done;
  logic mem_req_m, mem_ready;

  logic a_go, a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fm, a_fw;
  logic b_go, b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fm, b_fw;
  logic [31:0] a_sc, a_fc, b_sc, b_fc;
  logic [8:0] va, vb;

  int checks = 0;
  int failures = 0;

  // Output vector order: stall_f stall_d stall_e stall_m flush_d flush_e flush_m flush_w mdu_go
  localparam logic [8:0] IDLE  = 9'b000000000;
  localparam logic [8:0] LUST  = 9'b110001000;
  localparam logic [8:0] REDIR = 9'b000011000;
  localparam logic [8:0] GO    = 9'b111000101;
  localparam logic [8:0] MWAIT = 9'b111000100;
  localparam logic [8:0] FRZ   = 9'b111100010;

  assign va = {a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fm, a_fw, a_go};
  assign vb = {b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fm, b_fw, b_go};

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_BUBBLES(1)) dut_a (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_used_d(rs1_used_d),
    .rs2_used_d(rs2_used_d), .rd_e(rd_e), .MemRead_e(MemRead_e), .redirect_e(redirect_e),
    .mdu_op_e(mdu_op_e), .mdu_done(mdu_done), .mdu_go(a_go), .mem_req_m(mem_req_m),
    .mem_ready(mem_ready), .stall_f(a_sf), .stall_d(a_sd), .stall_e(a_se), .stall_m(a_sm),
    .flush_d(a_fd), .flush_e(a_fe), .flush_m(a_fm), .flush_w(a_fw),
    .stall_cycles(a_sc), .flush_count(a_fc));

  hazard_ctrl #(.LOAD_BUBBLES(2)) dut_b (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_used_d(rs1_used_d),
    .rs2_used_d(rs2_used_d), .rd_e(rd_e), .MemRead_e(MemRead_e), .redirect_e(redirect_e),
    .mdu_op_e(mdu_op_e), .mdu_done(mdu_done), .mdu_go(b_go), .mem_req_m(mem_req_m),
    .mem_ready(mem_ready), .stall_f(b_sf), .stall_d(b_sd), .stall_e(b_se), .stall_m(b_sm),
    .flush_d(b_fd), .flush_e(b_fe), .flush_m(b_fm), .flush_w(b_fw),
    .stall_cycles(b_sc), .flush_count(b_fc));

  task automatic clear_inputs();
    rs1_d = 5'd0; rs2_d = 5'd0; rd_e = 5'd0;
    rs1_used_d = 1'b0; rs2_used_d = 1'b0; MemRead_e = 1'b0;
    redirect_e = 1'b0; mdu_op_e = 1'b0; mdu_done = 1'b0;
    mem_req_m = 1'b0; mem_ready = 1'b1;
  endtask

  // Leaves the bench at negedge+1 with reset released; next_cycle() moves to the next drive point.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (va !== IDLE || vb !== IDLE) begin
      failures++;
      $display("FAIL reset_outputs a=%b b=%b expected %b", va, vb, IDLE);
    end
    checks++;
    if (a_sc !== 32'd0 || a_fc !== 32'd0 || b_sc !== 32'd0 || b_fc !== 32'd0) begin
      failures++;
      $display("FAIL reset_counters a=%0d/%0d b=%0d/%0d expected 0", a_sc, a_fc, b_sc, b_fc);
    end
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    do_reset();
    next_cycle();
    MemRead_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5; rs1_used_d = 1'b1;
    @(negedge clk);
    checks++;
    if (va !== LUST || vb !== LUST) begin
      failures++;
      $display("FAIL lu_first a=%b b=%b expected %b", va, vb, LUST);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (va !== IDLE || vb !== LUST) begin
      failures++;
      $display("FAIL lu_second a=%b b=%b expected a=%b b=%b", va, vb, IDLE, LUST);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (va !== IDLE || vb !== IDLE || a_sc !== 32'd1 || b_sc !== 32'd2) begin
      failures++;
      $display("FAIL lu_done a=%b b=%b sc_a=%0d sc_b=%0d expected idle, 1, 2", va, vb, a_sc, b_sc);
    end
    // rd_e = x0 never creates a dependency
    next_cycle();
    MemRead_e = 1'b1; rd_e = 5'd0; rs1_d = 5'd0; rs1_used_d = 1'b1;
    @(negedge clk);
    checks++;
    if (va !== IDLE || vb !== IDLE) begin
      failures++;
      $display("FAIL lu_x0 a=%b b=%b expected %b", va, vb, IDLE);
    end
    // rs2 match, then rs2 match with rs2 unused
    next_cycle();
    clear_inputs();
    do_reset();
    next_cycle();
    MemRead_e = 1'b1; rd_e = 5'd7; rs1_d = 5'd3; rs1_used_d = 1'b1; rs2_d = 5'd7; rs2_used_d = 1'b1;
    @(negedge clk);
    checks++;
    if (va !== LUST) begin
      failures++;
      $display("FAIL lu_rs2 a=%b expected %b", va, LUST);
    end
    next_cycle();
    clear_inputs();
    next_cycle();
    MemRead_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7; rs2_used_d = 1'b0;
    @(negedge clk);
    checks++;
    if (va !== IDLE) begin
      failures++;
      $display("FAIL lu_rs2_unused a=%b expected %b", va, IDLE);
    end
    $display("test_load_use done");
  endtask

  task automatic test_lu_redirect();
    do_reset();
    next_cycle();
    MemRead_e = 1'b1; rd_e = 5'd9; rs1_d = 5'd9; rs1_used_d = 1'b1;
    next_cycle();
    clear_inputs();
    redirect_e = 1'b1;
    @(negedge clk);
    checks++;
    if (va !== REDIR || vb !== REDIR) begin
      failures++;
      $display("FAIL lu_redirect a=%b b=%b expected %b", va, vb, REDIR);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (vb !== IDLE || b_fc !== 32'd1 || b_sc !== 32'd1 || a_fc !== 32'd1) begin
      failures++;
      $display("FAIL lu_redirect_after b=%b fc_b=%0d sc_b=%0d fc_a=%0d expected idle,1,1,1",
               vb, b_fc, b_sc, a_fc);
    end
    $display("test_lu_redirect done");
  endtask

  task automatic test_mdu();
    int se_cnt;
    int go_cnt;
    se_cnt = 0;
    go_cnt = 0;
    do_reset();
    next_cycle();
    mdu_op_e = 1'b1;
    @(negedge clk);
    checks++;
    if (va !== GO) begin
      failures++;
      $display("FAIL mdu_start a=%b expected %b", va, GO);
    end
    for (int i = 0; i < 5; i++) begin
      if (a_se === 1'b1 && a_fm === 1'b1) se_cnt++;
      if (a_go === 1'b1) go_cnt++;
      next_cycle();
      if (i == 4) mdu_done = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (va !== IDLE) begin
      failures++;
      $display("FAIL mdu_release a=%b expected %b", va, IDLE);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    if (a_go === 1'b1) go_cnt++;
    checks++;
    if (se_cnt != 5 || go_cnt != 1 || a_sc !== 32'd5) begin
      failures++;
      $display("FAIL mdu_counts stall_e=%0d go=%0d sc=%0d expected 5,1,5", se_cnt, go_cnt, a_sc);
    end
    $display("test_mdu done");
  endtask

  task automatic test_freeze_overlap();
    do_reset();
    next_cycle();
    mdu_op_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      mem_req_m = 1'b1; mem_ready = 1'b0;
      mdu_done = (i == 1);
      @(negedge clk);
      checks++;
      if (va !== FRZ) begin
        failures++;
        $display("FAIL freeze_cycle%0d a=%b expected %b", i, va, FRZ);
      end
    end
    next_cycle();
    mdu_done = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (va !== IDLE) begin
      failures++;
      $display("FAIL freeze_release a=%b expected %b", va, IDLE);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (va !== IDLE || a_sc !== 32'd4) begin
      failures++;
      $display("FAIL freeze_after a=%b sc=%0d expected %b,4", va, a_sc, IDLE);
    end
    $display("test_freeze_overlap done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    next_cycle();
    mdu_op_e = 1'b1;
    next_cycle();
    mem_req_m = 1'b1; mem_ready = 1'b0; mdu_done = 1'b1;
    next_cycle();
    clear_inputs();
    mdu_op_e = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (va !== IDLE && va !== GO) begin
      failures++;
      $display("FAIL reset_mid_outputs a=%b expected %b or fresh go", va, IDLE);
    end
    mdu_op_e = 1'b0;
    #1;
    checks++;
    if (va !== IDLE || a_sc !== 32'd0 || a_fc !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid a=%b sc=%0d fc=%0d expected %b,0,0", va, a_sc, a_fc, IDLE);
    end
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    mdu_op_e = 1'b1;
    @(negedge clk);
    checks++;
    if (va !== GO) begin
      failures++;
      $display("FAIL reset_mid_go a=%b expected %b", va, GO);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (va !== MWAIT) begin
      failures++;
      $display("FAIL reset_mid_wait a=%b expected %b", va, MWAIT);
    end
    next_cycle();
    clear_inputs();
    $display("test_reset_mid done");
  endtask

  task automatic test_counter_wrap();
    do_reset();
    force dut_a.stall_cycles_q = 32'hFFFF_FFFF;
    #1;
    release dut_a.stall_cycles_q;
    next_cycle();
    MemRead_e = 1'b1; rd_e = 5'd4; rs1_d = 5'd4; rs1_used_d = 1'b1;
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (a_sc !== 32'h0000_0000) begin
      failures++;
      $display("FAIL counter_wrap sc=%h expected 00000000", a_sc);
    end
    $display("test_counter_wrap done");
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_lu_redirect();
    test_mdu();
    test_freeze_overlap();
    test_reset_mid();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
